aes_trace_sequencer: RTL and testbench

- Synthesisable stimulus sequencer that drives AES_top through a parametrised run of encryptions, one per power trace, and captures each ciphertext.
- Sits between the bench or on-chip controller and AES_top, replacing hand-timed AES_en/AES_data_in sequences.
- Generalises single-shot stimulus to NUM_TRACES encryptions with LFSR plaintexts, programmable enable hold and inter-trace gap, and a completion timeout.

---
 rtl/aes_seq_pkg.sv | 18 +
 rtl/aes_seq_lfsr.sv | 35 +++
 rtl/aes_trace_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_trace_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES trace sequencer and its plaintext LFSR.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRIVE,
    WAIT,
    CAPTURE,
    GAP,
    DONE
  } seq_state_e;

  // Feedback taps for x^128 + x^7 + x^2 + x + 1, applied when the MSB shifts out
  localparam logic [127:0] LFSR_TAP      = 128'h87;
  localparam logic [127:0] LFSR_ZERO_SUB = 128'h1;

endpackage

// File: rtl/aes_seq_lfsr.sv
// Left-shifting Galois LFSR that supplies one fresh plaintext per trace.
// A zero seed would lock the register at zero, so it is replaced on load.
module aes_seq_lfsr
  import aes_seq_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              advance,
  output logic [DATA_W-1:0] next_val
);

  logic [DATA_W-1:0] state_q;
  logic [DATA_W-1:0] state_d;

  always_comb begin
    next_val = {state_q[DATA_W-2:0], 1'b0} ^
               (state_q[DATA_W-1] ? DATA_W'(LFSR_TAP) : '0);
    state_d  = state_q;
    if (load) begin
      state_d = (load_val == '0) ? DATA_W'(LFSR_ZERO_SUB) : load_val;
    end else if (advance) begin
      state_d = next_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/aes_trace_sequencer.sv
// Drives AES_top through NUM_TRACES encryptions and captures each ciphertext.
// Define AES_SEQ_TVLA_EN to interleave a fixed plaintext (even traces) with LFSR plaintexts.
module aes_trace_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int NUM_TRACES  = 16,
  parameter int EN_HOLD_CYC = 51,
  parameter int GAP_CYC     = 15,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] key_cfg,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] fixed_pt,
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [DATA_W-1:0] AES_key_in,
  input  logic              AES_data_out_valid,
  input  logic [DATA_W-1:0] AES_data_out,
  output logic              ct_valid,
  output logic [DATA_W-1:0] ct_out,
  output logic [DATA_W-1:0] pt_out,
  output logic [CNT_W-1:0]  trace_idx,
  output logic              busy,
  output logic              done,
`ifdef AES_SEQ_TVLA_EN
  output logic              tvla_class,
`endif
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(EN_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TRACE_LAST = CNT_W'(NUM_TRACES - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, trace_idx_q, trace_idx_d;
  logic [DATA_W-1:0] key_q, key_d, fixed_q, fixed_d, ct_hold_q, ct_hold_d;
  logic [DATA_W-1:0] data_in_q, data_in_d, key_in_q, key_in_d;
  logic [DATA_W-1:0] ct_out_q, ct_out_d, pt_out_q, pt_out_d;
  logic              seen_q, seen_d, valid_prev_q;
  logic              aes_en_q, aes_en_d, busy_q, busy_d, done_q, done_d;
  logic              ct_valid_q, ct_valid_d, timeout_err_q, timeout_err_d;
  logic              tvla_class_q, tvla_class_d;
  logic              lfsr_load, lfsr_adv, next_trace, use_fixed, val_rise;
  logic [DATA_W-1:0] lfsr_next;

  aes_seq_lfsr #(.DATA_W(DATA_W)) u_lfsr (
    .clk      (AES_clk),
    .rst_n    (AES_rst_n),
    .load     (lfsr_load),
    .load_val (seed),
    .advance  (lfsr_adv),
    .next_val (lfsr_next)
  );

  // Only a fresh rising edge counts, so a valid level left over from the previous trace is ignored
  assign val_rise = AES_data_out_valid & ~valid_prev_q;

`ifdef AES_SEQ_TVLA_EN
  assign use_fixed = ~trace_idx_q[0];
`else
  assign use_fixed = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    trace_idx_d   = trace_idx_q;
    key_d         = key_q;
    fixed_d       = fixed_q;
    ct_hold_d     = ct_hold_q;
    seen_d        = seen_q;
    data_in_d     = data_in_q;
    key_in_d      = key_in_q;
    ct_out_d      = ct_out_q;
    pt_out_d      = pt_out_q;
    timeout_err_d = timeout_err_q;
    tvla_class_d  = tvla_class_q;
    lfsr_load     = 1'b0;
    lfsr_adv      = 1'b0;
    next_trace    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d         = key_cfg;
          fixed_d       = fixed_pt;
          lfsr_load     = 1'b1;
          trace_idx_d   = '0;
          timeout_err_d = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        data_in_d = use_fixed ? fixed_q : lfsr_next;
        lfsr_adv  = ~use_fixed;
        key_in_d  = key_q;
        cnt_d     = '0;
        seen_d    = 1'b0;
        state_d   = DRIVE;
      end
      DRIVE: begin
        if (val_rise && !seen_q) begin
          seen_d    = 1'b1;
          ct_hold_d = AES_data_out;
        end
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (seen_q || val_rise) ? CAPTURE : WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (val_rise) begin
          state_d = CAPTURE;
        end else if (cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        cnt_d = '0;
        if (GAP_CYC == 0) next_trace = 1'b1;
        else              state_d    = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) next_trace = 1'b1;
        else                   cnt_d      = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (next_trace) begin
      if (trace_idx_q == TRACE_LAST) begin
        state_d = DONE;
      end else begin
        trace_idx_d = trace_idx_q + CNT_W'(1);
        state_d     = LOAD;
      end
    end

    // A valid seen during DRIVE was parked in ct_hold; otherwise it is on the bus right now
    if (state_d == CAPTURE) begin
      ct_out_d     = seen_q ? ct_hold_q : AES_data_out;
      pt_out_d     = data_in_q;
      tvla_class_d = trace_idx_q[0];
    end

    aes_en_d   = (state_d == DRIVE);
    busy_d     = state_d inside {LOAD, DRIVE, WAIT, CAPTURE, GAP};
    done_d     = (state_d == DONE);
    ct_valid_d = (state_d == CAPTURE);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      trace_idx_q   <= '0;
      key_q         <= '0;
      fixed_q       <= '0;
      ct_hold_q     <= '0;
      seen_q        <= 1'b0;
      valid_prev_q  <= 1'b0;
      data_in_q     <= '0;
      key_in_q      <= '0;
      ct_out_q      <= '0;
      pt_out_q      <= '0;
      aes_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ct_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tvla_class_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      trace_idx_q   <= trace_idx_d;
      key_q         <= key_d;
      fixed_q       <= fixed_d;
      ct_hold_q     <= ct_hold_d;
      seen_q        <= seen_d;
      valid_prev_q  <= AES_data_out_valid;
      data_in_q     <= data_in_d;
      key_in_q      <= key_in_d;
      ct_out_q      <= ct_out_d;
      pt_out_q      <= pt_out_d;
      aes_en_q      <= aes_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ct_valid_q    <= ct_valid_d;
      timeout_err_q <= timeout_err_d;
      tvla_class_q  <= tvla_class_d;
    end
  end

  assign AES_en      = aes_en_q;
  assign AES_data_in = data_in_q;
  assign AES_key_in  = key_in_q;
  assign ct_valid    = ct_valid_q;
  assign ct_out      = ct_out_q;
  assign pt_out      = pt_out_q;
  assign trace_idx   = trace_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
`ifdef AES_SEQ_TVLA_EN
  assign tvla_class  = tvla_class_q;
`else
  logic unused_tvla_class;
  assign unused_tvla_class = tvla_class_q;
`endif

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: behavioural AES responder plus a trace-level reference model.
// Build with AES_SEQ_TVLA_EN defined to exercise the fixed/random interleave.
module tb_aes_trace_sequencer;

  localparam int DATA_W      = 128;
  localparam int NUM_TRACES  = 4;
  localparam int EN_HOLD_CYC = 51;
  localparam int GAP_CYC     = 3;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 16;
`ifdef AES_SEQ_TVLA_EN
  localparam bit TVLA = 1'b1;
`else
  localparam bit TVLA = 1'b0;
`endif

  logic              AES_clk = 1'b0;
  logic              AES_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] key_cfg = '0, seed = '0, fixed_pt = '0;
  logic              AES_en;
  logic [DATA_W-1:0] AES_data_in, AES_key_in;
  logic              AES_data_out_valid = 1'b0;
  logic [DATA_W-1:0] AES_data_out = '0;
  logic              ct_valid, busy, done, timeout_err;
  logic [DATA_W-1:0] ct_out, pt_out;
  logic [CNT_W-1:0]  trace_idx;
  logic              tvla_class;

  aes_trace_sequencer #(
    .DATA_W(DATA_W), .NUM_TRACES(NUM_TRACES), .EN_HOLD_CYC(EN_HOLD_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .start(start),
    .key_cfg(key_cfg), .seed(seed), .fixed_pt(fixed_pt),
    .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
    .AES_data_out_valid(AES_data_out_valid), .AES_data_out(AES_data_out),
    .ct_valid(ct_valid), .ct_out(ct_out), .pt_out(pt_out),
    .trace_idx(trace_idx), .busy(busy), .done(done),
`ifdef AES_SEQ_TVLA_EN
    .tvla_class(tvla_class),
`endif
    .timeout_err(timeout_err)
  );

`ifndef AES_SEQ_TVLA_EN
  assign tvla_class = 1'b0;
`endif

  initial forever #5 AES_clk = ~AES_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lfsr_adv(input logic [127:0] s);
    return (s << 1) ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  // Stand-in for AES: any keyed, position-sensitive mixing will do for checking the capture path
  function automatic logic [127:0] aes_fn(input logic [127:0] pt, input logic [127:0] key);
    return {pt[63:0], pt[127:64]} ^ key ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // AES responder: aes_mode 0 = one-cycle pulse dly[i] cycles after AES_en rises, 1 = never, 2 = hold high
  int run_id = 0;
  int aes_mode = 0;
  int dly [NUM_TRACES];
  int m_run = 0, m_idx = 0, m_cnt = 0;
  bit m_en_prev = 1'b0;
  logic [127:0] m_pt, m_key;

  always @(negedge AES_clk) begin
    if (run_id != m_run) begin
      m_run = run_id;
      m_idx = 0;
      m_cnt = 0;
    end
    if (AES_data_out_valid && aes_mode != 2) AES_data_out_valid = 1'b0;
    if (!AES_data_out_valid) AES_data_out = {$urandom, $urandom, $urandom, $urandom};
    if (AES_en && !m_en_prev) begin
      m_pt  = AES_data_in;
      m_key = AES_key_in;
      if (aes_mode != 1 && !(aes_mode == 2 && AES_data_out_valid) && m_idx < NUM_TRACES)
        m_cnt = dly[m_idx] - 1;
      m_idx++;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        AES_data_out_valid = 1'b1;
        AES_data_out       = aes_fn(m_pt, m_key);
      end
    end
    m_en_prev = AES_en;
  end

  // Monitor: records what the sequencer did, per run
  int mon_cyc = 0, mon_run = 0;
  bit mon_en_prev = 1'b0, mon_to_prev = 1'b0;
  int rise_q[$], len_q[$], ct_cyc_q[$], idx_q[$], ct_idx_q[$], cls_q[$];
  logic [127:0] pt_q[$], key_q[$], ct_q[$], ptout_q[$];
  logic [127:0] cur_pt, cur_key;
  int en_len = 0, unstable = 0, done_cnt = 0, done_cyc = 0, last_fall = 0, to_rise = -1;
  bit done_to = 1'b0;

  always @(negedge AES_clk) begin
    mon_cyc++;
    if (run_id != mon_run) begin
      mon_run = run_id;
      rise_q.delete(); len_q.delete(); ct_cyc_q.delete(); idx_q.delete();
      ct_idx_q.delete(); cls_q.delete(); pt_q.delete(); key_q.delete();
      ct_q.delete(); ptout_q.delete();
      unstable = 0; done_cnt = 0; to_rise = -1;
    end
    if (AES_en && !mon_en_prev) begin
      rise_q.push_back(mon_cyc);
      pt_q.push_back(AES_data_in);
      key_q.push_back(AES_key_in);
      idx_q.push_back(int'(trace_idx));
      cur_pt  = AES_data_in;
      cur_key = AES_key_in;
      en_len  = 0;
    end
    if (AES_en) begin
      en_len++;
      if (AES_data_in !== cur_pt || AES_key_in !== cur_key) unstable++;
    end
    if (!AES_en && mon_en_prev) begin
      len_q.push_back(en_len);
      last_fall = mon_cyc;
    end
    if (ct_valid) begin
      ct_q.push_back(ct_out);
      ptout_q.push_back(pt_out);
      ct_idx_q.push_back(int'(trace_idx));
      cls_q.push_back(int'(tvla_class));
      ct_cyc_q.push_back(mon_cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = mon_cyc;
      done_to  = timeout_err;
    end
    if (timeout_err && !mon_to_prev) to_rise = mon_cyc;
    mon_en_prev = AES_en;
    mon_to_prev = timeout_err;
  end

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] s,
                               input logic [127:0] f, input int mode);
    aes_mode = mode;
    key_cfg  = k;
    seed     = s;
    fixed_pt = f;
    run_id++;
    @(negedge AES_clk);
    start = 1'b1;
    @(negedge AES_clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string nm);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge AES_clk);
    checkOutput({nm, ".finished"}, done_cnt != 0, 1'b1);
    repeat (4) @(negedge AES_clk);
  endtask

  // Reference: derive plaintexts from the seed and the trace outcome from the responder mode
  task automatic checkRun(input string nm, input logic [127:0] k, input logic [127:0] s,
                          input logic [127:0] f, input int mode);
    logic [127:0] lf;
    logic [127:0] exp_pt [NUM_TRACES];
    int ntr, nct, w;
    lf = (s == 0) ? 128'h1 : s;
    for (int i = 0; i < NUM_TRACES; i++) begin
      if (TVLA && (i % 2 == 0)) exp_pt[i] = f;
      else begin
        lf = lfsr_adv(lf);
        exp_pt[i] = lf;
      end
    end
    ntr = (mode == 0) ? NUM_TRACES : (mode == 1) ? 1 : 2;
    nct = (mode == 0) ? NUM_TRACES : (mode == 1) ? 0 : 1;
    checkOutput({nm, ".traces"}, rise_q.size(), ntr);
    checkOutput({nm, ".captures"}, ct_q.size(), nct);
    checkOutput({nm, ".done_pulses"}, done_cnt, 1);
    checkOutput({nm, ".timeout_err"}, done_to, mode != 0);
    checkOutput({nm, ".stable_in_drive"}, unstable, 0);
    for (int i = 0; i < rise_q.size() && i < ntr; i++) begin
      checkOutput($sformatf("%s.pt%0d", nm, i), pt_q[i], exp_pt[i]);
      checkOutput($sformatf("%s.key%0d", nm, i), key_q[i], k);
      checkOutput($sformatf("%s.idx%0d", nm, i), idx_q[i], i);
    end
    for (int i = 0; i < len_q.size() && i < ntr; i++)
      checkOutput($sformatf("%s.en_len%0d", nm, i), len_q[i], EN_HOLD_CYC);
    for (int i = 0; i < ct_q.size() && i < nct; i++) begin
      checkOutput($sformatf("%s.ct%0d", nm, i), ct_q[i], aes_fn(exp_pt[i], k));
      checkOutput($sformatf("%s.pt_out%0d", nm, i), ptout_q[i], exp_pt[i]);
      checkOutput($sformatf("%s.ct_idx%0d", nm, i), ct_idx_q[i], i);
      if (TVLA) checkOutput($sformatf("%s.class%0d", nm, i), cls_q[i], i % 2);
    end
    if (mode == 0) begin
      for (int i = 0; i + 1 < rise_q.size(); i++) begin
        w = (dly[i] > EN_HOLD_CYC) ? dly[i] - EN_HOLD_CYC : 0;
        checkOutput($sformatf("%s.budget%0d", nm, i), rise_q[i+1] - rise_q[i],
                    1 + EN_HOLD_CYC + w + 1 + GAP_CYC);
      end
      if (ct_cyc_q.size() > 0)
        checkOutput({nm, ".done_after_gap"}, done_cyc - ct_cyc_q[$], GAP_CYC + 1);
    end
    if (mode == 1) begin
      checkOutput({nm, ".timeout_latency"}, to_rise - last_fall, TIMEOUT_CYC);
      checkOutput({nm, ".done_with_timeout"}, done_cyc - to_rise, 0);
    end
  endtask

  logic [127:0] k, s, f;

  initial begin
    // Reset state
    #12;
    checkOutput("reset.ctrl", {AES_en, busy, done, ct_valid, timeout_err}, 5'b0);
    checkOutput("reset.data", AES_data_in | AES_key_in | ct_out | pt_out, 128'h0);
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    repeat (3) @(negedge AES_clk);
    checkOutput("idle.busy", busy, 1'b0);

    // Directed: known key, seed 1, fixed valid latency of 11 cycles
    k = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    f = 128'h00000049_00000000_00000000_00000000;
    for (int i = 0; i < NUM_TRACES; i++) dly[i] = 11;
    applyStimulus(k, 128'h1, f, 0);
    checkOutput("run1.busy_after_start", busy, 1'b1);
    waitDone("run1");
    checkRun("run1", k, 128'h1, f, 0);
    if (pt_q.size() > 1) begin
      checkOutput("run1.first_pt", pt_q[0], TVLA ? f : 128'h2);
      checkOutput("run1.second_pt", pt_q[1], TVLA ? 128'h2 : 128'h4);
    end

    // Random key/seed and latencies on both sides of the hold window; a stray start mid-run
    k = {$urandom, $urandom, $urandom, $urandom};
    s = {$urandom, $urandom, $urandom, $urandom};
    f = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NUM_TRACES; i++) dly[i] = $urandom_range(100, 3);
    applyStimulus(k, s, f, 0);
    for (int i = 0; i < 2000 && rise_q.size() < 2; i++) @(negedge AES_clk);
    key_cfg = ~k;
    seed    = ~s;
    start   = 1'b1;
    @(negedge AES_clk);
    start = 1'b0;
    waitDone("run2");
    checkRun("run2", k, s, f, 0);

    // Zero seed is substituted
    k = {$urandom, $urandom, $urandom, $urandom};
    f = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NUM_TRACES; i++) dly[i] = $urandom_range(100, 3);
    applyStimulus(k, 128'h0, f, 0);
    waitDone("run3");
    checkRun("run3", k, 128'h0, f, 0);

    // AES never answers
    k = {$urandom, $urandom, $urandom, $urandom};
    s = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(k, s, f, 1);
    waitDone("run4");
    checkRun("run4", k, s, f, 1);
    checkOutput("run4.sticky", timeout_err, 1'b1);

    // Valid held high: one capture, the next trace times out; start clears timeout_err
    dly[0] = $urandom_range(60, 5);
    k = {$urandom, $urandom, $urandom, $urandom};
    s = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(k, s, f, 2);
    checkOutput("run5.timeout_cleared", timeout_err, 1'b0);
    waitDone("run5");
    checkRun("run5", k, s, f, 2);
    aes_mode = 0;
    repeat (3) @(negedge AES_clk);

    // Asynchronous reset during DRIVE of trace 2
    for (int i = 0; i < NUM_TRACES; i++) dly[i] = 20;
    applyStimulus(k, s, f, 0);
    for (int i = 0; i < 2000 && rise_q.size() < 3; i++) @(negedge AES_clk);
    repeat (10) @(negedge AES_clk);
    checkOutput("rst.en_before", AES_en, 1'b1);
    #2 AES_rst_n = 1'b0;
    #1;
    checkOutput("rst.ctrl", {AES_en, busy, done, ct_valid, timeout_err}, 5'b0);
    checkOutput("rst.idx", trace_idx, 0);
    checkOutput("rst.data", AES_data_in | AES_key_in | ct_out | pt_out, 128'h0);
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    repeat (150) @(negedge AES_clk);
    checkOutput("rst.idle", {busy, AES_en}, 2'b0);

    // Normal operation after the abort
    k = {$urandom, $urandom, $urandom, $urandom};
    s = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NUM_TRACES; i++) dly[i] = $urandom_range(100, 3);
    applyStimulus(k, s, f, 0);
    waitDone("run7");
    checkRun("run7", k, s, f, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
